// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// Drives a single external mod_mul unit; owns the running product and exponent bit counter.
module mod_exp_ctrl #(
    parameter int unsigned W = 192,
    localparam int unsigned CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exp,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] mm_x,
    output logic [W-1:0] mm_y,
    output logic         mm_start,
    input  logic [W-1:0] mm_z,
    input  logic         mm_done
);

    typedef enum logic [2:0] {
        StIdle,
        StSkip,
        StSq,
        StMul,
        StGapSq,
        StGapMul,
        StFin
    } state_e;

    localparam logic [CW-1:0] CntMax = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  base_q, base_d;
    logic [W-1:0]  e_q, e_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  mm_x_q, mm_x_d;
    logic [W-1:0]  mm_y_q, mm_y_d;
    logic          mm_start_q, mm_start_d;

    logic [W-1:0]  e_shift;
    logic          last_bit;

    assign e_shift  = {e_q[W-2:0], 1'b0};
    assign last_bit = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            e_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_x_q     <= '0;
            mm_y_q     <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            e_q        <= e_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mm_x_q     <= mm_x_d;
            mm_y_q     <= mm_y_d;
            mm_start_q <= mm_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        e_d        = e_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mm_x_d     = mm_x_q;
        mm_y_d     = mm_y_q;
        mm_start_d = mm_start_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base;
                    e_d     = exp;
                    cnt_d   = CntMax;
                    busy_d  = 1'b1;
                    state_d = StSkip;
                end
            end
            // Leading zeros are skipped; the first set bit seeds acc with base.
            StSkip: begin
                e_d = e_shift;
                if (e_q[W-1]) begin
                    acc_d = base_q;
                    if (last_bit) begin
                        state_d = StFin;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = StGapSq;
                    end
                end else if (last_bit) begin
                    acc_d   = W'(1);
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGapSq: begin
                mm_x_d     = acc_q;
                mm_y_d     = acc_q;
                mm_start_d = 1'b1;
                state_d    = StSq;
            end
            StGapMul: begin
                mm_x_d     = acc_q;
                mm_y_d     = base_q;
                mm_start_d = 1'b1;
                state_d    = StMul;
            end
            StSq: begin
                if (mm_done) begin
                    acc_d      = mm_z;
                    mm_start_d = 1'b0;
                    if (e_q[W-1]) begin
                        state_d = StGapMul;
                    end else begin
                        e_d = e_shift;
                        if (last_bit) begin
                            state_d = StFin;
                        end else begin
                            cnt_d   = cnt_q - 1'b1;
                            state_d = StGapSq;
                        end
                    end
                end
            end
            StMul: begin
                if (mm_done) begin
                    acc_d      = mm_z;
                    mm_start_d = 1'b0;
                    e_d        = e_shift;
                    if (last_bit) begin
                        state_d = StFin;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = StGapSq;
                    end
                end
            end
            StFin: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mm_x     = mm_x_q;
    assign mm_y     = mm_y_q;
    assign mm_start = mm_start_q;

endmodule
